uart_tx_arbiter: RTL

// - Shares one UART transmitter between N_REQ byte-stream requesters (button/edge-driven message

---
 rtl/uart_tx_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-granular arbiter sharing one UART transmitter
// Optional stall release in LOAD is enabled by defining ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   grant,
    output logic [7:0]         tx_data,
    output logic               tx_start,
    input  logic               tx_busy,
    output logic               timeout
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_START    = 3'd2;
    localparam logic [2:0] S_WAIT_ACC = 3'd3;
    localparam logic [2:0] S_DRAIN    = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [PW-1:0]    gidx_q, gidx_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             last_q, last_d;

    logic [7:0]       req_byte [N_REQ];
    logic             found;
    logic [PW-1:0]    pick;
    logic [PW-1:0]    scan_idx;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign req_byte[gi] = req_data[8*gi +: 8];
    end

    // Scan ptr+1, ptr+2, ... so the last owner has the lowest priority next round.
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        scan_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            scan_idx = PW'((int'(ptr_q) + k) % N_REQ);
            if (!found && req_valid[scan_idx]) begin
                found = 1'b1;
                pick  = scan_idx;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SW-1:0] stall_q, stall_d;
    logic          timeout_q, timeout_d;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        tx_data_d = tx_data_q;
        last_d    = last_q;
        req_ready = '0;
`ifdef ARB_TIMEOUT_EN
        stall_d   = '0;
        timeout_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!tx_busy && found) begin
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    gidx_d        = pick;
                    state_d       = S_LOAD;
                end
            end
            S_LOAD: begin
                req_ready[gidx_q] = req_valid[gidx_q];
                if (req_valid[gidx_q]) begin
                    tx_data_d = req_byte[gidx_q];
                    last_d    = req_last[gidx_q];
                    state_d   = S_START;
                end
`ifdef ARB_TIMEOUT_EN
                // The stall that would bring the count to TIMEOUT_CYCLES releases the grant.
                else if (stall_q == SW'(TIMEOUT_CYCLES - 1)) begin
                    grant_d   = '0;
                    ptr_d     = gidx_q;
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
`endif
            end
            S_START: begin
                state_d = S_WAIT_ACC;
            end
            S_WAIT_ACC: begin
                if (tx_busy) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        grant_d = '0;
                        ptr_d   = gidx_q;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            ptr_q     <= PW'(N_REQ - 1);
            tx_data_q <= 8'h00;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            ptr_q     <= ptr_d;
            tx_data_q <= tx_data_d;
            last_q    <= last_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign grant    = grant_q;
    assign tx_data  = tx_data_q;
    assign tx_start = (state_q == S_START);

endmodule
